// File: rtl/iir_ch_sched.sv
// Channel-multiplexed sequencer for y[n] = B0*x[n] + A1_NEG*y[n-1] over shared external FP mult/add.
// Optional build macro IIR_CH_SCHED_FLUSH_EN adds a flush input that clears all channel state.
module iir_ch_sched #(
  parameter int MAN = 23,
  parameter int EXP = 8,
  parameter int NCH = 4,
  parameter logic [MAN+EXP:0] B0     = 32'h75d2d845,
  parameter logic [MAN+EXP:0] A1_NEG = 32'h745d4952,
  localparam int W  = MAN + EXP + 1,
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [CW-1:0] in_ch,
  input  logic [W-1:0]  in_x,
`ifdef IIR_CH_SCHED_FLUSH_EN
  input  logic          flush,
`endif
  output logic [W-1:0]  mul_a,
  output logic [W-1:0]  mul_b,
  input  logic [W-1:0]  mul_p,
  output logic [W-1:0]  add_a,
  output logic [W-1:0]  add_b,
  input  logic [W-1:0]  add_s,
  output logic          out_valid,
  output logic [CW-1:0] out_ch,
  output logic [W-1:0]  out_y,
  output logic          drop
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MULX,
    S_MULY,
    S_ADD
`ifdef IIR_CH_SCHED_FLUSH_EN
    , S_FLUSH
`endif
  } st_t;

  st_t           st;
  logic [CW-1:0] ch_p0;
  logic [W-1:0]  yz_p1;
  logic [W-1:0]  y_mem [NCH];
  logic          ch_ok;
`ifdef IIR_CH_SCHED_FLUSH_EN
  logic [CW-1:0] fl_cnt;
`endif

  // Zero-extend so the range test stays meaningful when NCH is a power of two.
  assign ch_ok = ({1'b0, in_ch} < (CW+1)'(NCH));

  // Operands are registered one state ahead so they are stable for the whole cycle that uses them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= S_IDLE;
      for (int i = 0; i < NCH; i++) y_mem[i] <= '0;
      ch_p0     <= '0;
      yz_p1     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      drop      <= 1'b0;
      out_ch    <= '0;
      out_y     <= '0;
      mul_a     <= '0;
      mul_b     <= '0;
      add_a     <= '0;
      add_b     <= '0;
`ifdef IIR_CH_SCHED_FLUSH_EN
      fl_cnt    <= '0;
`endif
    end else begin
      out_valid <= 1'b0;
      drop      <= 1'b0;
      mul_a     <= '0;
      mul_b     <= '0;
      add_a     <= '0;
      add_b     <= '0;
      case (st)
        // p0: accept sample, stage x*B0 operands
        S_IDLE: begin
`ifdef IIR_CH_SCHED_FLUSH_EN
          if (flush) begin
            st       <= S_FLUSH;
            in_ready <= 1'b0;
            fl_cnt   <= '0;
          end else
`endif
          if (in_valid) begin
            ch_p0 <= in_ch;
            if (ch_ok) begin
              st       <= S_MULX;
              in_ready <= 1'b0;
              mul_a    <= B0;
              mul_b    <= in_x;
            end else begin
              drop <= 1'b1;
            end
          end
        end
        // p1: capture B0*x, stage feedback product
        S_MULX: begin
          yz_p1 <= mul_p;
          mul_a <= A1_NEG;
          mul_b <= y_mem[ch_p0];
          st    <= S_MULY;
        end
        // p2: capture feedback product straight into the adder operand
        S_MULY: begin
          add_a <= yz_p1;
          add_b <= mul_p;
          st    <= S_ADD;
        end
        // p3: write back and emit
        S_ADD: begin
          y_mem[ch_p0] <= add_s;
          out_y        <= add_s;
          out_ch       <= ch_p0;
          out_valid    <= 1'b1;
          in_ready     <= 1'b1;
          st           <= S_IDLE;
        end
`ifdef IIR_CH_SCHED_FLUSH_EN
        S_FLUSH: begin
          y_mem[fl_cnt] <= '0;
          if (fl_cnt == CW'(NCH - 1)) begin
            st       <= S_IDLE;
            in_ready <= 1'b1;
          end else begin
            fl_cnt <= fl_cnt + 1'b1;
          end
        end
`endif
        default: begin
          st       <= S_IDLE;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iir_ch_sched.sv
// Scoreboarded bench for iir_ch_sched; real-valued stand-ins model the external FP mult/add.
module tb_iir_ch_sched;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    int          ch;
    logic [31:0] y;
    int          cyc;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];

  // dut1: B0=1.0, A1_NEG=0.5, NCH=4; dut2: default coefficients, NCH=3
  logic        iv1, ir1, ov1, dr1, iv2, ir2, ov2, dr2;
  logic [1:0]  ich1, och1, ich2, och2;
  logic [31:0] ix1, ma1, mb1, mp1, aa1, ab1, as1, oy1;
  logic [31:0] ix2, ma2, mb2, mp2, aa2, ab2, as2, oy2;
`ifdef IIR_CH_SCHED_FLUSH_EN
  logic        fl1, fl2;
`endif

  function automatic real f2r(input logic [31:0] b);
    real m;
    int  e;
    if (b[30:0] == 31'h0) return 0.0;
    m = 1.0 + real'(b[22:0]) / 8388608.0;
    e = int'(b[30:23]) - 127;
    for (int i = 0; i < e; i++) m = m * 2.0;
    for (int i = 0; i < -e; i++) m = m / 2.0;
    return b[31] ? -m : m;
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic        s;
    real         m;
    int          e;
    logic [22:0] man;
    if (r == 0.0) return 32'h0;
    s = (r < 0.0);
    m = s ? -r : r;
    e = 0;
    while (m >= 2.0) begin m = m / 2.0; e++; end
    while (m < 1.0) begin m = m * 2.0; e--; end
    if (e > 127) return {s, 8'hFF, 23'h0};
    if (e < -126) return {s, 31'h0};
    man = 23'($rtoi((m - 1.0) * 8388608.0));
    return {s, 8'(e + 127), man};
  endfunction

  always_comb mp1 = r2f(f2r(ma1) * f2r(mb1));
  always_comb as1 = r2f(f2r(aa1) + f2r(ab1));
  always_comb mp2 = r2f(f2r(ma2) * f2r(mb2));
  always_comb as2 = r2f(f2r(aa2) + f2r(ab2));

  iir_ch_sched #(.MAN(23), .EXP(8), .NCH(4), .B0(32'h3F800000), .A1_NEG(32'h3F000000)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .in_ch(ich1), .in_x(ix1),
`ifdef IIR_CH_SCHED_FLUSH_EN
    .flush(fl1),
`endif
    .mul_a(ma1), .mul_b(mb1), .mul_p(mp1), .add_a(aa1), .add_b(ab1), .add_s(as1),
    .out_valid(ov1), .out_ch(och1), .out_y(oy1), .drop(dr1)
  );

  iir_ch_sched #(.MAN(23), .EXP(8), .NCH(3)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2), .in_ch(ich2), .in_x(ix2),
`ifdef IIR_CH_SCHED_FLUSH_EN
    .flush(fl2),
`endif
    .mul_a(ma2), .mul_b(mb2), .mul_p(mp2), .add_a(aa2), .add_b(ab2), .add_s(as2),
    .out_valid(ov2), .out_ch(och2), .out_y(oy2), .drop(dr2)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, req, $time);
    end
  endtask

  always @(negedge clk) begin : mon1
    exp_t e;
    if (rst_n && ov1 === 1'b1) begin
      if (q1.size() == 0) chk("dut1 unexpected out_valid", 32'd1, 32'd0);
      else begin
        e = q1.pop_front();
        chk("dut1 out_y", oy1, e.y);
        chk("dut1 out_ch", 32'(och1), e.ch);
        chk("dut1 latency", cyc, e.cyc);
      end
    end
  end

  always @(negedge clk) begin : mon2
    exp_t e;
    if (rst_n && ov2 === 1'b1) begin
      if (q2.size() == 0) chk("dut2 unexpected out_valid", 32'd1, 32'd0);
      else begin
        e = q2.pop_front();
        chk("dut2 out_y", oy2, e.y);
        chk("dut2 out_ch", 32'(och2), e.ch);
        chk("dut2 latency", cyc, e.cyc);
      end
    end
  end

  function automatic logic rdy(input int d);
    return (d == 1) ? ir1 : ir2;
  endfunction

  // Called right after a negedge; drives one sample and waits for the accepting edge.
  task automatic send(input int d, input int ch, input logic [31:0] x, input logic [31:0] y,
                      input bit push, input bit rdychk);
    int   n;
    exp_t e;
    n = 0;
    while (rdy(d) !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    if (rdy(d) !== 1'b1) chk("in_ready wait timeout", 32'd0, 32'd1);
    if (d == 1) begin iv1 = 1'b1; ich1 = 2'(ch); ix1 = x; end
    else        begin iv2 = 1'b1; ich2 = 2'(ch); ix2 = x; end
    @(posedge clk);
    #1;
    iv1 = 1'b0;
    iv2 = 1'b0;
    e.ch  = ch;
    e.y   = y;
    e.cyc = cyc + 3;
    if (push) begin
      if (d == 1) q1.push_back(e);
      else        q2.push_back(e);
    end
    if (rdychk) begin
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        chk("in_ready low after accept", 32'(rdy(d)), 32'd0);
      end
      @(negedge clk);
      chk("in_ready high after result", 32'(rdy(d)), 32'd1);
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  initial begin : stim
    iv1 = 1'b0; ich1 = '0; ix1 = '0;
    iv2 = 1'b0; ich2 = '0; ix2 = '0;
`ifdef IIR_CH_SCHED_FLUSH_EN
    fl1 = 1'b0; fl2 = 1'b0;
`endif
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    chk("reset in_ready",  32'(ir1), 32'd1);
    chk("reset out_valid", 32'(ov1), 32'd0);
    chk("reset drop",      32'(dr1), 32'd0);
    chk("reset out_ch",    32'(och1), 32'd0);
    chk("reset out_y",     oy1, 32'h0);
    chk("reset mul_a",     ma1, 32'h0);
    chk("reset mul_b",     mb1, 32'h0);
    chk("reset add_a",     aa1, 32'h0);
    chk("reset add_b",     ab1, 32'h0);
    chk("reset dut2 in_ready", 32'(ir2), 32'd1);

    // Same channel back-to-back: 1.0, then 1.0 + 0.5*1.0
    send(1, 0, 32'h3F800000, 32'h3F800000, 1'b1, 1'b1);
    send(1, 0, 32'h3F800000, 32'h3FC00000, 1'b1, 1'b1);
    repeat (2) @(negedge clk);

    // Default coefficients, operand muxing per state
    send(2, 2, 32'h40000000, 32'h7652d845, 1'b1, 1'b0);
    @(negedge clk);
    chk("MULX mul_a", ma2, 32'h75d2d845);
    chk("MULX mul_b", mb2, 32'h40000000);
    chk("MULX add_a", aa2, 32'h0);
    @(negedge clk);
    chk("MULY mul_a", ma2, 32'h745d4952);
    chk("MULY mul_b", mb2, 32'h0);
    chk("MULY add_a", aa2, 32'h0);
    @(negedge clk);
    chk("ADD add_a", aa2, 32'h7652d845);
    chk("ADD add_b", ab2, 32'h0);
    chk("ADD mul_a", ma2, 32'h0);
    repeat (2) @(negedge clk);

    // Out-of-range channel on NCH=3
    send(2, 3, 32'h3F800000, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    chk("drop pulse",          32'(dr2), 32'd1);
    chk("drop out_valid",      32'(ov2), 32'd0);
    chk("drop in_ready",       32'(ir2), 32'd1);
    @(negedge clk);
    chk("drop one cycle",      32'(dr2), 32'd0);
    chk("drop no out_valid",   32'(ov2), 32'd0);

    // ch2 state must still hold the earlier result; 0.0 in gives A1_NEG*state which overflows to +inf
    send(2, 2, 32'h00000000, 32'h7F800000, 1'b1, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("ch2 state after drop", mb2, 32'h7652d845);
    repeat (4) @(negedge clk);

    // Reset during MULY discards the transaction
    send(1, 0, 32'h3F800000, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("async reset in_ready", 32'(ir1), 32'd1);
    chk("async reset mul_a",    ma1, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("no output after abort", 32'(ov1), 32'd0);
    end

    // Interleaved channels after reset
    send(1, 0, 32'h3F800000, 32'h3F800000, 1'b1, 1'b1);
    send(1, 1, 32'h3F800000, 32'h3F800000, 1'b1, 1'b1);
    send(1, 0, 32'h3F800000, 32'h3FC00000, 1'b1, 1'b1);

`ifdef IIR_CH_SCHED_FLUSH_EN
    send(1, 1, 32'h3F800000, 32'h3FC00000, 1'b1, 1'b1);
    fl1 = 1'b1; iv1 = 1'b1; ich1 = 2'd1; ix1 = 32'h3F800000;
    @(posedge clk);
    #1;
    fl1 = 1'b0; iv1 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("flush in_ready low", 32'(ir1), 32'd0);
    end
    @(negedge clk);
    chk("flush in_ready back", 32'(ir1), 32'd1);
    send(1, 1, 32'h3F800000, 32'h3F800000, 1'b1, 1'b1);
`endif

    repeat (6) @(negedge clk);
    chk("dut1 queue drained", 32'(q1.size()), 32'd0);
    chk("dut2 queue drained", 32'(q2.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/iir_ch_sched.md
Name: iir_ch_sched

Overview:
- Time-multiplexed controller for the first-order floating-point IIR recurrence y[n] = B0*x[n] + A1_NEG*y[n-1].
- Services NCH independent channels with one shared single-cycle FP multiplier (mult) and one shared FP adder (soma), both instantiated outside this block.
- Holds per-channel y[n-1] state, sequences operand muxing into the shared units, captures results, and emits one output word per accepted sample.
- Sits between the int2float front end and downstream float consumers.

Parameters:
- MAN, 23, mantissa width; float word is MAN+EXP+1 bits.
- EXP, 8, exponent width.
- NCH, 4, number of channels (1..16); CW = max(1, $clog2(NCH)).
- B0, 32'h75d2d845, feed-forward coefficient (float).
- A1_NEG, 32'h745d4952, negated feedback coefficient (float).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  sample present.
- in_ready  out  1  block can accept a sample.
- in_ch  in  CW  channel index of the sample.
- in_x  in  MAN+EXP+1  sample, float format.
- mul_a, mul_b  out  MAN+EXP+1 each  shared multiplier operands.
- mul_p  in  MAN+EXP+1  shared multiplier product (combinational, same cycle).
- add_a, add_b  out  MAN+EXP+1 each  shared adder operands.
- add_s  in  MAN+EXP+1  shared adder sum (combinational, same cycle).
- out_valid  out  1  one-cycle result strobe.
- out_ch  out  CW  channel of result.
- out_y  out  MAN+EXP+1  result y[n].
- drop  out  1  one-cycle strobe: sample with in_ch >= NCH was discarded.

Behaviour:
- Reset (async assert, sync release): FSM=IDLE; all state[ch]=0; x_r, yz_r, yp_r=0; in_ready=1; out_valid=0; drop=0; out_ch=0; out_y=0; mul/add operands=0. Reset mid-transaction discards the transaction with no output.
- Handshake: transfer occurs on a clk edge where in_valid && in_ready. in_ready=1 only in IDLE. No output backpressure.
- FSM:
  - IDLE: on transfer, latch x_r and ch_r. If in_ch >= NCH, pulse drop next cycle and stay IDLE. Otherwise go to MULX.
  - MULX: mul_a=B0, mul_b=x_r; yz_r<=mul_p; go to MULY.
  - MULY: mul_a=A1_NEG, mul_b=state[ch_r]; yp_r<=mul_p; go to ADD.
  - ADD: add_a=yz_r, add_b=yp_r; state[ch_r]<=add_s; out_y<=add_s; out_ch<=ch_r; out_valid<=1; go to IDLE.
- Operands are 0 in every state that does not use them; mul and add outputs are registered.
- Latency: out_valid rises 3 edges after the accepting edge (transfer at edge k, out_valid high during cycle k+3 to k+4). Throughput is one sample per 4 cycles per block; in_ready returns high in the same cycle out_valid is high.
- Back-to-back samples on the same channel use the state updated by the previous ADD.
- Channels are fully independent. No arithmetic is done inside the block; float width and rounding are those of mult and soma.

Optional Feature:
- Macro IIR_CH_SCHED_FLUSH_EN.
- Defined:
  - Adds input port flush (1 bit) and state FLUSH.
  - flush=1 in IDLE has priority over in_valid: no transfer that cycle, enter FLUSH.
  - FLUSH zeroes state[0..NCH-1], one entry per cycle in ascending order, over NCH cycles, then returns to IDLE. in_ready=0 throughout.
  - flush asserted outside IDLE is ignored.
- Undefined: no flush port; state is cleared only by rst_n.

Test Plan:
- Override B0=32'h3F800000 and A1_NEG=32'h3F000000. Ch0 receives x=32'h3F800000 twice back-to-back → out_y=32'h3F800000, then 32'h3FC00000. Each out_valid comes exactly 3 edges after its accept; in_ready is low for 3 cycles after each accept.
- Same overrides, interleaved ch0, ch1, ch0 with x=1.0 → outputs 3F800000 (ch0), 3F800000 (ch1), 3FC00000 (ch0); out_ch matches each.
- Default coefficients, ch2 with x=32'h40000000 → in MULX mul_a=75d2d845 and mul_b=40000000; in MULY mul_a=745d4952 and mul_b=0; in ADD add_a/add_b equal the captured products.
- NCH=3, in_ch=3 → drop pulses 1 cycle, out_valid stays 0, state unchanged, in_ready high again next cycle.
- Assert rst_n=0 during MULY of a ch0 transaction → no out_valid; after release, ch0 with x=1.0 gives 3F800000 (state was cleared).
- IIR_CH_SCHED_FLUSH_EN defined, NCH=4: build ch1 state to 3FC00000, then flush and in_valid in the same IDLE cycle → flush wins; in_ready=0 for 4 cycles; next ch1 x=1.0 gives 3F800000.
